// File: rtl/prbs31_sync_ctrl_if.sv
// Bus for the PRBS31 sync checker: received stream in,
// lock state and error statistics out.
interface prbs31_sync_ctrl_if #(
  parameter int WORDWIDTH = 15
);
  logic                 enTMR;
  logic                 dataValidTMR;
  logic [WORDWIDTH-1:0] dataTMR;
  logic                 clrErrTMR;
  logic [1:0]           stateTMR;
  logic                 lockedTMR;
  logic                 errFlagTMR;
  logic [15:0]          errCntTMR;

  modport master (
    output enTMR,
    output dataValidTMR,
    output dataTMR,
    output clrErrTMR,
    input  stateTMR,
    input  lockedTMR,
    input  errFlagTMR,
    input  errCntTMR
  );

  modport slave (
    input  enTMR,
    input  dataValidTMR,
    input  dataTMR,
    input  clrErrTMR,
    output stateTMR,
    output lockedTMR,
    output errFlagTMR,
    output errCntTMR
  );
endinterface

// File: rtl/prbs31_sync_ctrl.sv
// PRBS31 (x^31+x^28+1) word-parallel sync checker:
// hunt/verify/locked FSM with saturating error counter.
module prbs31_sync_ctrl #(
  parameter int WORDWIDTH   = 15,
  parameter int LOCKCOUNT   = 8,
  parameter int UNLOCKCOUNT = 4
) (
  input logic               clkTMR,
  input logic               resetTMR,
  prbs31_sync_ctrl_if.slave bus
);
  localparam int CAPW = (31 + WORDWIDTH - 1) / WORDWIDTH;
  localparam int CAPB = CAPW * WORDWIDTH;
  localparam logic [2:0] CAP_LAST = 3'(CAPW - 1);
  localparam logic [7:0] LOCK_N   = 8'(LOCKCOUNT);
  localparam logic [7:0] UNLOCK_N = 8'(UNLOCKCOUNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [30:0] cap, cap_nxt;
  logic [30:0] expd, expd_nxt;
  logic [2:0]  cap_cnt, cap_cnt_nxt;
  logic [7:0]  good, good_nxt;
  logic [7:0]  bad, bad_nxt;
  logic        locked, locked_nxt;
  logic        err_flag, err_flag_nxt;
  logic [15:0] err_cnt, err_cnt_nxt;
  logic        sample;
  logic        match;

  function automatic logic [30:0] step1(
    input logic [30:0] s
  );
    return {s[3] ^ s[0], s[30:1]};
  endfunction

  function automatic logic [30:0] adv_word(
    input logic [30:0] s
  );
    logic [30:0] r;
    r = s;
    for (int i = 0; i < WORDWIDTH; i++)
      r = step1(r);
    return r;
  endfunction

  function automatic logic [30:0] adv_cap(
    input logic [30:0] s
  );
    logic [30:0] r;
    r = s;
    for (int i = 0; i < CAPB; i++)
      r = step1(r);
    return r;
  endfunction

  assign sample = bus.enTMR & bus.dataValidTMR;
  assign match  = bus.dataTMR == expd[WORDWIDTH-1:0];

  always_comb begin
    state_nxt    = state;
    cap_nxt      = cap;
    expd_nxt     = expd;
    cap_cnt_nxt  = cap_cnt;
    good_nxt     = good;
    bad_nxt      = bad;
    err_flag_nxt = 1'b0;
    err_cnt_nxt  = err_cnt;
    locked_nxt   = 1'b0;
    if (!bus.enTMR) begin
      state_nxt   = HUNT;
      cap_cnt_nxt = '0;
      good_nxt    = '0;
      bad_nxt     = '0;
    end else if (sample) begin
      unique case (state)
        HUNT: begin
          // word k fills capture bits k*W.. (only 31 are kept)
          for (int b = 0; b < 31; b++)
            if (b / WORDWIDTH == int'(cap_cnt))
              cap_nxt[b] = bus.dataTMR[b % WORDWIDTH];
          if (cap_cnt == CAP_LAST) begin
            expd_nxt    = adv_cap(cap_nxt);
            state_nxt   = VERIFY;
            good_nxt    = '0;
            cap_cnt_nxt = '0;
          end else begin
            cap_cnt_nxt = cap_cnt + 3'd1;
          end
        end
        VERIFY: begin
          if (match) begin
            expd_nxt = adv_word(expd);
            good_nxt = good + 8'd1;
            if (good_nxt == LOCK_N) begin
              state_nxt = LOCKED;
              bad_nxt   = '0;
            end
          end else begin
            state_nxt   = HUNT;
            cap_cnt_nxt = '0;
          end
        end
        LOCKED: begin
          expd_nxt = adv_word(expd);
          if (match) begin
            bad_nxt = '0;
          end else begin
            bad_nxt      = bad + 8'd1;
            err_flag_nxt = 1'b1;
            if (err_cnt != 16'hFFFF)
              err_cnt_nxt = err_cnt + 16'd1;
            if (bad_nxt == UNLOCK_N) begin
              state_nxt   = HUNT;
              cap_cnt_nxt = '0;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
    if (bus.clrErrTMR)
      err_cnt_nxt = '0;
    locked_nxt = state_nxt == LOCKED;
  end

  always_ff @(posedge clkTMR or posedge resetTMR) begin
    if (resetTMR) begin
      state    <= HUNT;
      cap      <= '0;
      expd     <= '0;
      cap_cnt  <= '0;
      good     <= '0;
      bad      <= '0;
      locked   <= 1'b0;
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      cap      <= cap_nxt;
      expd     <= expd_nxt;
      cap_cnt  <= cap_cnt_nxt;
      good     <= good_nxt;
      bad      <= bad_nxt;
      locked   <= locked_nxt;
      err_flag <= err_flag_nxt;
      err_cnt  <= err_cnt_nxt;
    end
  end

  assign bus.stateTMR   = state;
  assign bus.lockedTMR  = locked;
  assign bus.errFlagTMR = err_flag;
  assign bus.errCntTMR  = err_cnt;
endmodule
